// File: rtl/tag_mem_pkg.sv
// ---------------------------------------------------------------------------
// tag_mem_pkg : shared types for the tag-cache memory-side responder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tag_mem_pkg;

  typedef enum logic [1:0] {
    ACQ_GET_BEAT  = 2'd0,
    ACQ_GET_BLOCK = 2'd1,
    ACQ_PUT_BEAT  = 2'd2,
    ACQ_PUT_BLOCK = 2'd3
  } acq_type_t;

  typedef enum logic {
    GNT_DATA    = 1'b0,
    GNT_PUT_ACK = 1'b1
  } gnt_type_t;

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_READ        = 2'd1,
    S_PUT_COLLECT = 2'd2,
    S_ACK         = 2'd3
  } state_t;

  // Each stored beat is {data, tag}.
  function automatic int entry_width(input int data_w, input int tag_w);
    return data_w + tag_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tag_mem_array.sv
// ---------------------------------------------------------------------------
// tag_mem_array : beat-addressed storage, one write port, one async read port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tag_mem_array #(
  parameter int AW = 10,
  parameter int DW = 68
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/tag_mem_responder.sv
// ---------------------------------------------------------------------------
// tag_mem_responder : Acquire/Grant memory responder with per-beat tag storage
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tag_mem_responder
  import tag_mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int BEATS  = 4,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 4,
  parameter int XID_W  = 4,
  localparam int BEAT_W = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              acq_valid,
  output logic              acq_ready,
  input  logic [1:0]        acq_type,
  input  logic [ADDR_W-1:0] acq_addr,
  input  logic [BEAT_W-1:0] acq_beat,
  input  logic [DATA_W-1:0] acq_data,
  input  logic [TAG_W-1:0]  acq_tag,
  input  logic [XID_W-1:0]  acq_xid,
  output logic              gnt_valid,
  input  logic              gnt_ready,
  output logic              gnt_type,
  output logic [BEAT_W-1:0] gnt_beat,
  output logic [DATA_W-1:0] gnt_data,
  output logic [TAG_W-1:0]  gnt_tag,
  output logic [XID_W-1:0]  gnt_xid,
  output logic              err
);

  localparam int ENTRY_W = entry_width(DATA_W, TAG_W);
  localparam int MADDR_W = ADDR_W + BEAT_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [XID_W-1:0]    xid_q, xid_d;
  logic                single_q, single_d;
  gnt_type_t           gnt_type_q, gnt_type_d;
  logic [BEAT_W-1:0]   gnt_beat_q, gnt_beat_d;
  logic [DATA_W-1:0]   gnt_data_q, gnt_data_d;
  logic [TAG_W-1:0]    gnt_tag_q, gnt_tag_d;
  logic [XID_W-1:0]    gnt_xid_q, gnt_xid_d;
  logic                err_q, err_d;

  logic                mem_we;
  logic [MADDR_W-1:0]  mem_waddr;
  logic [ENTRY_W-1:0]  mem_wdata;
  logic [MADDR_W-1:0]  mem_raddr;
  logic [ENTRY_W-1:0]  mem_rdata;

  acq_type_t           acq_kind;
  logic                acq_fire;
  logic                gnt_fire;

  assign acq_kind  = acq_type_t'(acq_type);
  assign acq_ready = (state_q == S_IDLE) || (state_q == S_PUT_COLLECT);
  assign gnt_valid = (state_q == S_READ) || (state_q == S_ACK);
  assign acq_fire  = acq_valid && acq_ready;
  assign gnt_fire  = gnt_valid && gnt_ready;

  tag_mem_array #(
    .AW (MADDR_W),
    .DW (ENTRY_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    xid_d      = xid_q;
    single_d   = single_q;
    gnt_type_d = gnt_type_q;
    gnt_beat_d = gnt_beat_q;
    gnt_data_d = gnt_data_q;
    gnt_tag_d  = gnt_tag_q;
    gnt_xid_d  = gnt_xid_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    mem_waddr  = {acq_addr, acq_beat};
    mem_wdata  = {acq_data, acq_tag};
    mem_raddr  = {acq_addr, acq_beat};

    case (state_q)
      S_IDLE: begin
        if (acq_fire) begin
          addr_d    = acq_addr;
          xid_d     = acq_xid;
          gnt_xid_d = acq_xid;
          case (acq_kind)
            ACQ_GET_BEAT, ACQ_GET_BLOCK: begin
              single_d   = (acq_kind == ACQ_GET_BEAT);
              cnt_d      = '0;
              mem_raddr  = (acq_kind == ACQ_GET_BEAT) ? {acq_addr, acq_beat}
                                                      : {acq_addr, {BEAT_W{1'b0}}};
              gnt_type_d = GNT_DATA;
              gnt_beat_d = mem_raddr[BEAT_W-1:0];
              gnt_data_d = mem_rdata[ENTRY_W-1:TAG_W];
              gnt_tag_d  = mem_rdata[TAG_W-1:0];
              state_d    = S_READ;
            end
            ACQ_PUT_BEAT: begin
              mem_we     = 1'b1;
              gnt_type_d = GNT_PUT_ACK;
              gnt_beat_d = '0;
              gnt_data_d = '0;
              gnt_tag_d  = '0;
              state_d    = S_ACK;
            end
            default: begin
              // A misnumbered first beat is flagged but still lands at beat 0.
              if (acq_beat != '0) begin
                err_d = 1'b1;
              end
              mem_we    = 1'b1;
              mem_waddr = {acq_addr, {BEAT_W{1'b0}}};
              cnt_d     = BEAT_ONE;
              state_d   = S_PUT_COLLECT;
            end
          endcase
        end
      end

      S_PUT_COLLECT: begin
        if (acq_fire) begin
          mem_we    = 1'b1;
          mem_waddr = {addr_q, cnt_q};
          if ((acq_beat != cnt_q) || (acq_kind != ACQ_PUT_BLOCK) ||
              (acq_xid != xid_q) || (acq_addr != addr_q)) begin
            err_d = 1'b1;
          end
          cnt_d = cnt_q + BEAT_ONE;
          if (cnt_q == LAST_BEAT) begin
            gnt_type_d = GNT_PUT_ACK;
            gnt_beat_d = '0;
            gnt_data_d = '0;
            gnt_tag_d  = '0;
            gnt_xid_d  = xid_q;
            state_d    = S_ACK;
          end
        end
      end

      S_READ: begin
        if (gnt_fire) begin
          if (single_q || (cnt_q == LAST_BEAT)) begin
            gnt_type_d = GNT_DATA;
            gnt_beat_d = '0;
            gnt_data_d = '0;
            gnt_tag_d  = '0;
            gnt_xid_d  = '0;
            cnt_d      = '0;
            state_d    = S_IDLE;
          end else begin
            // Next beat goes into the grant regs on the same edge: no bubble.
            cnt_d      = cnt_q + BEAT_ONE;
            mem_raddr  = {addr_q, cnt_q + BEAT_ONE};
            gnt_beat_d = cnt_q + BEAT_ONE;
            gnt_data_d = mem_rdata[ENTRY_W-1:TAG_W];
            gnt_tag_d  = mem_rdata[TAG_W-1:0];
          end
        end
      end

      default: begin
        if (gnt_fire) begin
          gnt_type_d = GNT_DATA;
          gnt_xid_d  = '0;
          cnt_d      = '0;
          state_d    = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      xid_q      <= '0;
      single_q   <= 1'b0;
      gnt_type_q <= GNT_DATA;
      gnt_beat_q <= '0;
      gnt_data_q <= '0;
      gnt_tag_q  <= '0;
      gnt_xid_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      xid_q      <= xid_d;
      single_q   <= single_d;
      gnt_type_q <= gnt_type_d;
      gnt_beat_q <= gnt_beat_d;
      gnt_data_q <= gnt_data_d;
      gnt_tag_q  <= gnt_tag_d;
      gnt_xid_q  <= gnt_xid_d;
      err_q      <= err_d;
    end
  end

  assign gnt_type = gnt_type_q;
  assign gnt_beat = gnt_beat_q;
  assign gnt_data = gnt_data_q;
  assign gnt_tag  = gnt_tag_q;
  assign gnt_xid  = gnt_xid_q;
  assign err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_tag_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_tag_mem_responder : directed vector table plus hand-written multi-cycle sequences
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tag_mem_responder;

  localparam logic [1:0] GB = 2'd0, GK = 2'd1, PB = 2'd2, PK = 2'd3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        acq_valid;
  logic        acq_ready;
  logic [1:0]  acq_type;
  logic [7:0]  acq_addr;
  logic [1:0]  acq_beat;
  logic [63:0] acq_data;
  logic [3:0]  acq_tag;
  logic [3:0]  acq_xid;
  logic        gnt_valid;
  logic        gnt_ready;
  logic        gnt_type;
  logic [1:0]  gnt_beat;
  logic [63:0] gnt_data;
  logic [3:0]  gnt_tag;
  logic [3:0]  gnt_xid;
  logic        err;

  int tests = 0;
  int fails = 0;

  tag_mem_responder dut (
    .clk       (clk),
    .rstn      (rstn),
    .acq_valid (acq_valid),
    .acq_ready (acq_ready),
    .acq_type  (acq_type),
    .acq_addr  (acq_addr),
    .acq_beat  (acq_beat),
    .acq_data  (acq_data),
    .acq_tag   (acq_tag),
    .acq_xid   (acq_xid),
    .gnt_valid (gnt_valid),
    .gnt_ready (gnt_ready),
    .gnt_type  (gnt_type),
    .gnt_beat  (gnt_beat),
    .gnt_data  (gnt_data),
    .gnt_tag   (gnt_tag),
    .gnt_xid   (gnt_xid),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  t;
    logic [7:0]  a;
    logic [1:0]  b;
    logic [63:0] d;
    logic [3:0]  g;
    logic [3:0]  x;
    logic        et;
    logic [1:0]  eb;
    logic [63:0] ed;
    logic [3:0]  eg;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called #1 after a posedge; returns #1 after the accepting edge.
  task automatic acq(input logic [1:0] t, input logic [7:0] a, input logic [1:0] b,
                     input logic [63:0] d, input logic [3:0] g, input logic [3:0] x);
    int n = 0;
    acq_valid = 1'b1; acq_type = t; acq_addr = a; acq_beat = b;
    acq_data = d; acq_tag = g; acq_xid = x;
    @(negedge clk);
    while (!acq_ready && n < 20) begin n++; @(negedge clk); end
    if (!acq_ready) begin
      fails++; tests++;
      $display("FAIL acq_timeout: acq_ready=%b expected 1", acq_ready);
    end
    @(posedge clk); #1;
    acq_valid = 1'b0;
  endtask

  // Expects a grant in the very next cycle; consumes it with gnt_ready=1.
  task automatic grant(input logic et, input logic [1:0] eb, input logic [63:0] ed,
                       input logic [3:0] eg, input logic [3:0] ex, input string nm);
    int n = 0;
    gnt_ready = 1'b1;
    @(negedge clk);
    while (!gnt_valid && n < 20) begin n++; @(negedge clk); end
    chk({nm, "_latency"}, 64'(n), 64'd0);
    chk({nm, "_type"}, 64'(gnt_type), 64'(et));
    chk({nm, "_beat"}, 64'(gnt_beat), 64'(eb));
    chk({nm, "_data"}, gnt_data, ed);
    chk({nm, "_tag"},  64'(gnt_tag), 64'(eg));
    chk({nm, "_xid"},  64'(gnt_xid), 64'(ex));
    @(posedge clk); #1;
  endtask

  task automatic idle_chk(input string nm);
    @(negedge clk);
    chk({nm, "_gnt_valid"}, 64'(gnt_valid), 64'd0);
    chk({nm, "_acq_ready"}, 64'(acq_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int i;
    rstn = 1'b0; acq_valid = 1'b0; gnt_ready = 1'b1;
    acq_type = '0; acq_addr = '0; acq_beat = '0; acq_data = '0; acq_tag = '0; acq_xid = '0;

    vecs[0] = '{PB, 8'h05, 2'd2, 64'hAA, 4'hF, 4'd1, 1'b1, 2'd0, 64'h0, 4'h0};
    vecs[1] = '{GB, 8'h05, 2'd2, 64'h0,  4'h0, 4'd2, 1'b0, 2'd2, 64'hAA, 4'hF};
    vecs[2] = '{GB, 8'h05, 2'd0, 64'h0,  4'h0, 4'd3, 1'b0, 2'd0, 64'h10, 4'h1};
    vecs[3] = '{PB, 8'hFF, 2'd3, 64'hDEAD_BEEF_0123_4567, 4'hA, 4'd4, 1'b1, 2'd0, 64'h0, 4'h0};
    vecs[4] = '{PB, 8'h00, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'h0, 4'hF, 1'b1, 2'd0, 64'h0, 4'h0};
    vecs[5] = '{GB, 8'hFF, 2'd3, 64'h0,  4'h0, 4'd5, 1'b0, 2'd3, 64'hDEAD_BEEF_0123_4567, 4'hA};
    vecs[6] = '{GB, 8'h00, 2'd0, 64'h0,  4'h0, 4'd6, 1'b0, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'h0};
    vecs[7] = '{PB, 8'hFF, 2'd3, 64'h1,  4'h5, 4'hE, 1'b1, 2'd0, 64'h0, 4'h0};
    vecs[8] = '{GB, 8'hFF, 2'd3, 64'h0,  4'h0, 4'd8, 1'b0, 2'd3, 64'h1, 4'h5};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_acq_ready", 64'(acq_ready), 64'd1);
    chk("rst_gnt_valid", 64'(gnt_valid), 64'd0);
    chk("rst_gnt_fields", {gnt_data ^ 64'(gnt_beat), 4'(gnt_tag), 4'(gnt_xid)} != '0, 64'd0);
    chk("rst_gnt_type", 64'(gnt_type), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // 1: PUT_BLOCK addr 5, ACK one cycle after the final beat
    for (int k = 0; k < 4; k++) acq(PK, 8'h05, 2'(k), 64'(8'h10 + k), 4'(k + 1), 4'd3);
    grant(1'b1, 2'd0, 64'h0, 4'h0, 4'd3, "t1_ack");
    chk("t1_err", 64'(err), 64'd0);

    // 2: GET_BLOCK back-to-back
    acq(GK, 8'h05, 2'd0, 64'h0, 4'h0, 4'd7);
    for (int k = 0; k < 4; k++)
      grant(1'b0, 2'(k), 64'(8'h10 + k), 4'(k + 1), 4'd7, $sformatf("t2_b%0d", k));
    idle_chk("t2_end");

    // 3: GET_BLOCK with gnt_ready pattern 1,0,0,1,...
    acq(GK, 8'h05, 2'd0, 64'h0, 4'h0, 4'd2);
    e = 0; i = 0;
    while (e < 4 && i < 40) begin
      gnt_ready = ((i % 4) == 0) || ((i % 4) == 3);
      @(negedge clk);
      chk($sformatf("t3_valid_c%0d", i), 64'(gnt_valid), 64'd1);
      chk($sformatf("t3_beat_c%0d", i), 64'(gnt_beat), 64'(e));
      chk($sformatf("t3_data_c%0d", i), gnt_data, 64'(8'h10 + e));
      chk($sformatf("t3_tag_c%0d", i), 64'(gnt_tag), 64'(e + 1));
      chk($sformatf("t3_acq_ready_c%0d", i), 64'(acq_ready), 64'd0);
      @(posedge clk);
      if (gnt_ready) e++;
      #1;
      i++;
    end
    chk("t3_all_beats", 64'(e), 64'd4);
    gnt_ready = 1'b1;
    idle_chk("t3_end");

    // 4: single-beat vector table
    for (int k = 0; k < 9; k++) begin
      acq(vecs[k].t, vecs[k].a, vecs[k].b, vecs[k].d, vecs[k].g, vecs[k].x);
      grant(vecs[k].et, vecs[k].eb, vecs[k].ed, vecs[k].eg, vecs[k].x, $sformatf("vec%0d", k));
    end
    acq(GK, 8'h05, 2'd0, 64'h0, 4'h0, 4'd9);
    grant(1'b0, 2'd0, 64'h10, 4'h1, 4'd9, "t4_b0");
    grant(1'b0, 2'd1, 64'h11, 4'h2, 4'd9, "t4_b1");
    grant(1'b0, 2'd2, 64'hAA, 4'hF, 4'd9, "t4_b2");
    grant(1'b0, 2'd3, 64'h13, 4'h4, 4'd9, "t4_b3");

    // 5: PUT_BLOCK with misnumbered second beat
    acq(PK, 8'h20, 2'd0, 64'h50, 4'h6, 4'd5);
    chk("t5_err_b0", 64'(err), 64'd0);
    acq(PK, 8'h20, 2'd2, 64'h51, 4'h7, 4'd5);
    chk("t5_err_b1", 64'(err), 64'd1);
    acq(PK, 8'h20, 2'd2, 64'h52, 4'h8, 4'd5);
    acq(PK, 8'h20, 2'd3, 64'h53, 4'h9, 4'd5);
    grant(1'b1, 2'd0, 64'h0, 4'h0, 4'd5, "t5_ack");
    acq(GK, 8'h20, 2'd0, 64'h0, 4'h0, 4'd6);
    for (int k = 0; k < 4; k++)
      grant(1'b0, 2'(k), 64'(8'h50 + k), 4'(k + 6), 4'd6, $sformatf("t5_rd%0d", k));
    chk("t5_err_sticky", 64'(err), 64'd1);

    // 6: reset in the middle of a GET_BLOCK
    acq(GK, 8'h05, 2'd0, 64'h0, 4'h0, 4'd4);
    grant(1'b0, 2'd0, 64'h10, 4'h1, 4'd4, "t6_b0");
    grant(1'b0, 2'd1, 64'h11, 4'h2, 4'd4, "t6_b1");
    rstn = 1'b0;
    #1;
    chk("t6_rst_gnt_valid", 64'(gnt_valid), 64'd0);
    chk("t6_rst_acq_ready", 64'(acq_ready), 64'd1);
    chk("t6_rst_err", 64'(err), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    acq(GB, 8'h05, 2'd3, 64'h0, 4'h0, 4'd9);
    grant(1'b0, 2'd3, 64'h13, 4'h4, 4'd9, "t6_after");
    idle_chk("t6_end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
